u_adder_exh_checker: RTL

- Sequential self-checking harness placed directly around a flat unsigned N-bit ripple-carry adder.
- Upstream role: drives the adder's a/b operands through all 2^(2N) combinations.
- Downstream role: samples the adder's N+1-bit result after a programmable settle time and compares it against a golden sum.
- Reports pass/fail, error count and first failing vector. Used for on-board/regression sign-off of generated adder netlists.

---
 rtl/u_adder_chk_pkg.sv | 26 ++
 rtl/u_adder_chk_vec_gen.sv | 59 +++++
 rtl/u_adder_exh_checker.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/u_adder_chk_pkg.sv
// Shared types and width helpers for the exhaustive adder checker.
package u_adder_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_t;

    function automatic int res_width(input int n);
        return n + 32'sd1;
    endfunction

    function automatic int vec_width(input int n);
        return 32'sd2 * n;
    endfunction

    function automatic int cnt_width(input int n);
        return (32'sd2 * n) + 32'sd1;
    endfunction

    function automatic logic [63:0] vec_total(input int n);
        return 64'd1 << (32'sd2 * n);
    endfunction

endpackage

// File: rtl/u_adder_chk_vec_gen.sv
// Operand sequencer: walks all 2^(2N) {b,a} vectors, holding each for
// SETTLE_CYCLES cycles and flagging the edge on which the result is sampled.
module u_adder_chk_vec_gen
    import u_adder_chk_pkg::*;
#(
    parameter int N             = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic         hold,
    output logic [N-1:0] dut_a,
    output logic [N-1:0] dut_b,
    output logic         sample,
    output logic         last
);

    localparam int VW = vec_width(N);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_ONE  = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [VW-1:0] VC_ONE      = {{(VW-1){1'b0}}, 1'b1};

    logic [VW-1:0] vc_r;
    logic [SW-1:0] settle_r;

    assign sample = en && (settle_r == SETTLE_LAST);
    assign last   = &vc_r;
    assign dut_a  = vc_r[N-1:0];
    assign dut_b  = vc_r[VW-1:N];

    // Vector and settle counters; the sampling edge also loads the next vector
    // unless this is the last one or the caller asks to freeze on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vc_r     <= {VW{1'b0}};
            settle_r <= {SW{1'b0}};
        end else if (load) begin
            vc_r     <= {VW{1'b0}};
            settle_r <= {SW{1'b0}};
        end else if (sample) begin
            settle_r <= {SW{1'b0}};
            if (!last && !hold) begin
                vc_r <= vc_r + VC_ONE;
            end else begin
                vc_r <= vc_r;
            end
        end else if (en) begin
            settle_r <= settle_r + SETTLE_ONE;
            vc_r     <= vc_r;
        end else begin
            settle_r <= settle_r;
            vc_r     <= vc_r;
        end
    end

endmodule

// File: rtl/u_adder_exh_checker.sv
// Exhaustive self-checking harness for an N-bit ripple-carry adder.
// Optional macro U_ADDER_EXH_CHECKER_STOP_ON_FAIL_EN: end the run on the first mismatch.
module u_adder_exh_checker
    import u_adder_chk_pkg::*;
#(
    parameter int N             = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic [N-1:0]   dut_a,
    output logic [N-1:0]   dut_b,
    input  logic [N:0]     dut_out,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*N:0]   err_count,
    output logic           ff_valid,
    output logic [N-1:0]   ff_a,
    output logic [N-1:0]   ff_b,
    output logic [N:0]     ff_out
);

    localparam int RW = res_width(N);
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] ERR_MAX = CW'(vec_total(N));
    localparam logic [CW-1:0] ERR_ONE = {{(CW-1){1'b0}}, 1'b1};

    chk_state_t    state_r;
    chk_state_t    state_next_s;
    logic          load_s;
    logic          finish_s;
    logic          en_s;
    logic          hold_s;
    logic          sample_s;
    logic          last_s;
    logic          mismatch_s;
    logic          count_s;
    logic [RW-1:0] golden_s;
    logic [CW-1:0] err_next_s;
    logic          busy_r;
    logic          done_r;
    logic          pass_r;
    logic [CW-1:0] err_count_r;
    logic          ff_valid_r;
    logic [N-1:0]  ff_a_r;
    logic [N-1:0]  ff_b_r;
    logic [RW-1:0] ff_out_r;

    assign en_s    = (state_r == ST_RUN);
    assign count_s = sample_s && mismatch_s;

`ifdef U_ADDER_EXH_CHECKER_STOP_ON_FAIL_EN
    assign hold_s = mismatch_s;
`else
    assign hold_s = 1'b0;
`endif

    u_adder_chk_vec_gen #(
        .N             (N),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_vec_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_s),
        .en     (en_s),
        .hold   (hold_s),
        .dut_a  (dut_a),
        .dut_b  (dut_b),
        .sample (sample_s),
        .last   (last_s)
    );

    // Golden compare; an unknown result fails the equality and lands in the mismatch branch.
    always_comb begin
        golden_s   = {1'b0, dut_a} + {1'b0, dut_b};
        mismatch_s = 1'b1;
        if (dut_out == golden_s) begin
            mismatch_s = 1'b0;
        end else begin
            mismatch_s = 1'b1;
        end
    end

    // Run control: start is honoured only from IDLE or DONE.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RUN: begin
                if (sample_s && (last_s || hold_s)) begin
                    state_next_s = ST_DONE;
                    finish_s     = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Saturating error count, cleared when a run is launched.
    always_comb begin
        err_next_s = err_count_r;
        if (load_s) begin
            err_next_s = {CW{1'b0}};
        end else if (count_s && (err_count_r != ERR_MAX)) begin
            err_next_s = err_count_r + ERR_ONE;
        end else begin
            err_next_s = err_count_r;
        end
    end

    // State and registered status / first-failure capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_count_r <= {CW{1'b0}};
            ff_valid_r  <= 1'b0;
            ff_a_r      <= {N{1'b0}};
            ff_b_r      <= {N{1'b0}};
            ff_out_r    <= {RW{1'b0}};
        end else begin
            state_r     <= state_next_s;
            busy_r      <= (state_next_s == ST_RUN);
            done_r      <= (state_next_s == ST_DONE);
            err_count_r <= err_next_s;
            if (load_s) begin
                pass_r <= 1'b0;
            end else if (finish_s) begin
                pass_r <= (err_next_s == {CW{1'b0}});
            end else begin
                pass_r <= pass_r;
            end
            if (load_s) begin
                ff_valid_r <= 1'b0;
                ff_a_r     <= {N{1'b0}};
                ff_b_r     <= {N{1'b0}};
                ff_out_r   <= {RW{1'b0}};
            end else if (count_s && !ff_valid_r) begin
                ff_valid_r <= 1'b1;
                ff_a_r     <= dut_a;
                ff_b_r     <= dut_b;
                ff_out_r   <= dut_out;
            end else begin
                ff_valid_r <= ff_valid_r;
                ff_a_r     <= ff_a_r;
                ff_b_r     <= ff_b_r;
                ff_out_r   <= ff_out_r;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_count_r;
    assign ff_valid  = ff_valid_r;
    assign ff_a      = ff_a_r;
    assign ff_b      = ff_b_r;
    assign ff_out    = ff_out_r;

endmodule
